// File: rtl/uart_debug_ctrl.sv
// uart_debug_ctrl: UART debug command sequencer (run/step CPU, dump debug words MSB-first)
module uart_debug_ctrl #(
  parameter int DBIT    = 8,
  parameter int DATA_W  = 32,
  parameter int N_WORDS = 8,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_empty,
  input  logic [DBIT-1:0]   r_data,
  output logic              rd_uart,
  output logic              wr_uart,
  output logic [DBIT-1:0]   w_data,
  input  logic              tx_done_tick,
  input  logic              cpu_halt,
  output logic              cpu_en,
  output logic [ADDR_W-1:0] dump_addr,
  input  logic [DATA_W-1:0] dump_data,
  output logic              busy
);
  localparam int NB = DATA_W / DBIT;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N_WORDS - 1);
  typedef enum logic [2:0] {IDLE, DECODE, RUN, STEP, LOAD, SEND, WAIT_TX} state_t;
  state_t r_state;
  logic [DBIT-1:0] r_cmd;
  logic [DATA_W-1:0] r_shift;
  logic [BW-1:0] r_byte_cnt;
  // Command sequencer: pops one command per IDLE visit, then runs/steps the CPU and streams the dump
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cmd <= '0;
      r_shift <= '0;
      r_byte_cnt <= '0;
      rd_uart <= 1'b0;
      wr_uart <= 1'b0;
      w_data <= '0;
      cpu_en <= 1'b0;
      dump_addr <= '0;
      busy <= 1'b0;
    end else begin
      rd_uart <= 1'b0;
      wr_uart <= 1'b0;
      case (r_state)
        IDLE: if (!rx_empty) begin
          r_cmd <= r_data;
          rd_uart <= 1'b1;
          busy <= 1'b1;
          r_state <= DECODE;
        end
        DECODE: case (r_cmd)
          DBIT'(8'h43): r_state <= RUN;
          DBIT'(8'h53): begin
            cpu_en <= 1'b1;
            r_state <= STEP;
          end
          DBIT'(8'h44): begin
            dump_addr <= '0;
            r_state <= LOAD;
          end
          default: begin
            busy <= 1'b0;
            r_state <= IDLE;
          end
        endcase
        RUN: begin
          cpu_en <= !cpu_halt;
          if (cpu_halt) begin
            dump_addr <= '0;
            r_state <= LOAD;
          end
        end
        STEP: begin
          cpu_en <= 1'b0;
          dump_addr <= '0;
          r_state <= LOAD;
        end
        LOAD: begin
          r_shift <= dump_data;
          r_byte_cnt <= '0;
          r_state <= SEND;
        end
        SEND: begin
          w_data <= r_shift[DATA_W-1 -: DBIT];
          wr_uart <= 1'b1;
          r_state <= WAIT_TX;
        end
        WAIT_TX: if (tx_done_tick) begin
          r_shift <= r_shift << DBIT;
          if (r_byte_cnt < LAST_BYTE) begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
            r_state <= SEND;
          end else if (dump_addr < LAST_WORD) begin
            dump_addr <= dump_addr + 1'b1;
            r_state <= LOAD;
          end else begin
            dump_addr <= '0;
            busy <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_debug_ctrl.sv
// tb_uart_debug_ctrl: directed self-checking bench for uart_debug_ctrl
module tb_uart_debug_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic rx_empty;
  logic [7:0] r_data;
  logic rd_uart, wr_uart, cpu_en, busy;
  logic [7:0] w_data;
  logic tx_done_tick, cpu_halt;
  logic [2:0] dump_addr;
  logic [31:0] dump_data;
  logic tx_m = 1'b0;
  logic spur;
  logic busy_q = 1'b0;
  logic [7:0] cmd_mem [0:15];
  logic [7:0] bytes [$];
  int rd_hist [$];
  int done_hist [$];
  int wp, rp = 0, cyc = 0, en_cnt = 0, overlap = 0, tx_cnt = 0, fall_cyc = 0;
  int npass = 0, ntot = 0;
  int bs, rs, ds, es;

  uart_debug_ctrl dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .wr_uart(wr_uart), .w_data(w_data), .tx_done_tick(tx_done_tick), .cpu_halt(cpu_halt),
    .cpu_en(cpu_en), .dump_addr(dump_addr), .dump_data(dump_data), .busy(busy)
  );

  always #5 clk = ~clk;
  assign rx_empty = (wp == rp);
  assign r_data = cmd_mem[rp % 16];
  assign dump_data = 32'hA0B0C0D0 + {29'd0, dump_addr};
  assign tx_done_tick = tx_m | spur;

  // Monitor, RX FIFO pop and TX model (done 10 cycles after each wr_uart), sampled mid-cycle
  initial forever begin
    @(negedge clk);
    cyc++;
    if (tx_m) done_hist.push_back(cyc);
    if (busy_q && !busy) fall_cyc = cyc;
    busy_q = busy;
    if (rd_uart) begin
      rd_hist.push_back(cyc);
      rp++;
    end
    if (cpu_en) en_cnt++;
    if (cpu_en && wr_uart) overlap++;
    tx_m = 1'b0;
    if (wr_uart) begin
      bytes.push_back(w_data);
      tx_cnt = 10;
    end else if (tx_cnt != 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_m = 1'b1;
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [7:0] b);
    cmd_mem[wp % 16] = b;
    wp++;
  endtask

  function automatic logic [7:0] exp_byte(int i);
    logic [31:0] w;
    w = 32'hA0B0C0D0 + 32'(i / 4);
    return w[31 - 8 * (i % 4) -: 8];
  endfunction

  task automatic chk_dump(int s);
    for (int i = 0; i < 32; i++)
      if (s + i < bytes.size()) chk("dump_byte", 32'(bytes[s + i]), 32'(exp_byte(i)));
      else chk("dump_len", 32'(bytes.size()), 32'(s + i + 1));
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    do begin
      tick;
      n++;
    end while (!(rp == wp && !busy && tx_cnt == 0 && !tx_m) && n < budget);
    chk("done_in_time", 32'(n < budget), 1);
  endtask

  task automatic wait_en(int budget);
    int n = 0;
    while (!cpu_en && n < budget) begin
      tick;
      n++;
    end
    chk("cpu_en_seen", 32'(cpu_en), 1);
  endtask

  task automatic chk_outs_zero(string tag);
    chk({tag, "_rd"}, 32'(rd_uart), 0);
    chk({tag, "_wr"}, 32'(wr_uart), 0);
    chk({tag, "_wdata"}, 32'(w_data), 0);
    chk({tag, "_cpu_en"}, 32'(cpu_en), 0);
    chk({tag, "_addr"}, 32'(dump_addr), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic snap;
    bs = bytes.size();
    rs = rd_hist.size();
    ds = done_hist.size();
    es = en_cnt;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    cpu_halt = 1'b0;
    spur = 1'b0;
    wp = 0;
    repeat (3) tick;
    chk_outs_zero("reset");
    reset = 1'b0;
    tick;
    // Reset in the middle of a dump
    snap;
    push(8'h44);
    n = 0;
    while (bytes.size() < bs + 5 && n < 1000) begin
      tick;
      n++;
    end
    chk("five_bytes_sent", 32'(bytes.size() - bs), 5);
    #3 reset = 1'b1;
    #1 chk_outs_zero("async_reset");
    tick;
    reset = 1'b0;
    snap;
    repeat (40) tick;
    chk("no_tx_after_reset", 32'(bytes.size() - bs), 0);
    chk("idle_after_reset", 32'(busy), 0);
    // Spurious done while idle
    spur = 1'b1;
    tick;
    spur = 1'b0;
    tick;
    chk("idle_spur_no_tx", 32'(bytes.size() - bs), 0);
    chk("idle_spur_busy", 32'(busy), 0);
    // Dump only
    snap;
    push(8'h44);
    wait_done(5000);
    chk("d_rd_pulses", 32'(rd_hist.size() - rs), 1);
    chk("d_bytes", 32'(bytes.size() - bs), 32);
    chk_dump(bs);
    chk("d_cpu_en", 32'(en_cnt - es), 0);
    chk("d_busy_fall", 32'(fall_cyc), 32'(done_hist[done_hist.size() - 1]));
    // Single step, spurious done held through IDLE/DECODE/STEP/LOAD
    snap;
    spur = 1'b1;
    push(8'h53);
    wait_en(20);
    tick;
    tick;
    spur = 1'b0;
    wait_done(5000);
    chk("s_cpu_en", 32'(en_cnt - es), 1);
    chk("s_rd_pulses", 32'(rd_hist.size() - rs), 1);
    chk("s_bytes", 32'(bytes.size() - bs), 32);
    chk_dump(bs);
    // Run until halt 100 cycles later, with a spurious done during RUN
    snap;
    push(8'h43);
    wait_en(20);
    for (int k = 0; k < 99; k++) begin
      spur = (k == 50);
      tick;
    end
    spur = 1'b0;
    cpu_halt = 1'b1;
    wait_done(5000);
    chk("c_cpu_en", 32'(en_cnt - es), 100);
    chk("c_bytes", 32'(bytes.size() - bs), 32);
    chk_dump(bs);
    // Run with halt already high
    snap;
    push(8'h43);
    wait_done(5000);
    chk("c_halted_cpu_en", 32'(en_cnt - es), 0);
    chk("c_halted_bytes", 32'(bytes.size() - bs), 32);
    chk_dump(bs);
    cpu_halt = 1'b0;
    // Unknown byte followed by two queued dumps
    snap;
    push(8'h7A);
    push(8'h44);
    push(8'h44);
    wait_done(10000);
    chk("q_rd_pulses", 32'(rd_hist.size() - rs), 3);
    chk("q_bytes", 32'(bytes.size() - bs), 64);
    chk_dump(bs);
    chk_dump(bs + 32);
    if (rd_hist.size() >= rs + 3 && done_hist.size() >= ds + 32) begin
      chk("q_unknown_spacing", 32'(rd_hist[rs + 1] - rd_hist[rs]), 2);
      chk("q_second_d_after_done", 32'(rd_hist[rs + 2]), 32'(done_hist[ds + 31] + 1));
    end else chk("q_history", 32'(rd_hist.size() - rs), 3);
    chk("no_en_wr_overlap", 32'(overlap), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
